add_multiword_sequencer: RTL and testbench

- Sequential wrapper that streams arbitrarily long operands as N-bit words (least-significant word first) through one combinational DataFlowCarrySkipAdd instance.
- Chains the carry between words in a register and supports add or subtract per frame.
- Sits between an operand-word producer (valid/ready) and a result-word consumer (valid/ready).
- Gives the FixedPointArithmetic datapath multi-precision add/sub without widening the adder.

---
 rtl/add_multiword_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_add_multiword_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_multiword_sequencer.sv
// add_multiword_sequencer
// Streams arbitrarily long operands, least-significant word first, through a
// single N-bit carry-skip adder. The carry is chained between words of a frame
// in a register, and each frame is either an add or a subtract (A-B).
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   s_valid / s_ready    operand word handshake
//   s_a, s_b             operand words
//   s_first, s_last      frame delimiters (least / most significant word)
//   s_sub                frame mode, sampled on the frame-start word
//   m_valid / m_ready    result word handshake
//   m_sum                result word
//   m_idx                word index within the frame
//   m_last               final word of the frame
//   m_co                 carry out of this word (subtract: 1 = no borrow)
//   m_ovf                signed overflow, only on the final word
//   m_err                framing error seen on this word

// Combinational carry-skip adder: ripple inside BLK-bit blocks, and a block
// whose bits all propagate forwards its carry-in directly.
module DataFlowCarrySkipAdd #(
    parameter int N   = 32,
    parameter int BLK = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] c,
    output logic         co
);

    // Bitwise ripple with a per-block skip multiplexer on the block carry.
    always_comb begin
        logic carry_v;
        logic blk_cin_v;
        logic blk_p_v;
        logic p_v;
        c         = {N{1'b0}};
        carry_v   = ci;
        blk_cin_v = ci;
        blk_p_v   = 1'b1;
        p_v       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((i % BLK) == 0) begin
                blk_cin_v = carry_v;
                blk_p_v   = 1'b1;
            end else begin
                blk_p_v   = blk_p_v;
            end
            p_v     = a[i] ^ b[i];
            c[i]    = p_v ^ carry_v;
            carry_v = (a[i] & b[i]) | (p_v & carry_v);
            blk_p_v = blk_p_v & p_v;
            if (((i % BLK) == (BLK - 1)) || (i == (N - 1))) begin
                carry_v = blk_p_v ? blk_cin_v : carry_v;
            end else begin
                carry_v = carry_v;
            end
        end
        co = carry_v;
    end

endmodule

module add_multiword_sequencer #(
    parameter int N    = 32,
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N-1:0]    s_a,
    input  logic [N-1:0]    s_b,
    input  logic            s_first,
    input  logic            s_last,
    input  logic            s_sub,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N-1:0]    m_sum,
    output logic [IDXW-1:0] m_idx,
    output logic            m_last,
    output logic            m_co,
    output logic            m_ovf,
    output logic            m_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t          state_r;
    logic            carry_r;
    logic            sub_r;
    logic [IDXW-1:0] idx_r;

    logic            accept_s;
    logic            start_s;
    logic            mode_s;
    logic            ci_s;
    logic            err_s;
    logic [N-1:0]    add_b_s;
    logic [N-1:0]    add_c_s;
    logic            add_co_s;
    logic [IDXW-1:0] idx_next_s;

    // Single output register: a new word fits whenever the current result leaves.
    assign s_ready  = !m_valid || m_ready;
    assign accept_s = s_valid && s_ready;

    // Frame-start detection, framing error and adder operand selection.
    always_comb begin
        start_s    = 1'b0;
        err_s      = 1'b0;
        mode_s     = 1'b0;
        ci_s       = 1'b0;
        idx_next_s = {IDXW{1'b0}};
        // Outside a frame every word starts one; a missing s_first is an error.
        // Inside a frame an unexpected s_first abandons the old frame.
        if (state_r == ST_IDLE) begin
            start_s = 1'b1;
            err_s   = !s_first;
        end else begin
            start_s = s_first;
            err_s   = s_first;
        end
        // A frame start discards the chained carry; subtract seeds ci=1 (+1 of two's complement).
        if (start_s) begin
            mode_s     = s_sub;
            ci_s       = s_sub;
            idx_next_s = {IDXW{1'b0}};
        end else begin
            mode_s     = sub_r;
            ci_s       = carry_r;
            idx_next_s = idx_r + IDXW'(1);
        end
        add_b_s = s_b ^ {N{mode_s}};
    end

    DataFlowCarrySkipAdd #(
        .N   (N),
        .BLK (4)
    ) u_adder (
        .a  (s_a),
        .b  (add_b_s),
        .ci (ci_s),
        .c  (add_c_s),
        .co (add_co_s)
    );

    // Frame FSM, carry chain and result register; everything holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            m_valid <= 1'b0;
            m_sum   <= {N{1'b0}};
            m_idx   <= {IDXW{1'b0}};
            m_last  <= 1'b0;
            m_co    <= 1'b0;
            m_ovf   <= 1'b0;
            m_err   <= 1'b0;
        end else if (accept_s) begin
            sub_r   <= mode_s;
            carry_r <= add_co_s;
            idx_r   <= idx_next_s;
            m_valid <= 1'b1;
            m_sum   <= add_c_s;
            m_idx   <= idx_next_s;
            m_last  <= s_last;
            m_co    <= add_co_s;
            m_ovf   <= s_last && (s_a[N-1] == add_b_s[N-1]) && (add_c_s[N-1] != s_a[N-1]);
            m_err   <= err_s;
            case (s_last)
                1'b1:    state_r <= ST_IDLE;
                1'b0:    state_r <= ST_FRAME;
                default: state_r <= ST_IDLE;
            endcase
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid;
        end
    end

endmodule

// File: tb/tb_add_multiword_sequencer.sv
module tb_add_multiword_sequencer;

    localparam int N    = 8;
    localparam int IDXW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [N-1:0]    s_a = '0;
    logic [N-1:0]    s_b = '0;
    logic            s_first = 1'b0;
    logic            s_last = 1'b0;
    logic            s_sub = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [N-1:0]    m_sum;
    logic [IDXW-1:0] m_idx;
    logic            m_last;
    logic            m_co;
    logic            m_ovf;
    logic            m_err;

    add_multiword_sequencer #(.N(N), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .s_first(s_first), .s_last(s_last), .s_sub(s_sub),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_idx(m_idx),
        .m_last(m_last), .m_co(m_co), .m_ovf(m_ovf), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    sum;
        logic [IDXW-1:0] idx;
        logic            last;
        logic            co;
        logic            ovf;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: frame bookkeeping in plain integers.
    int   mf_in_frame = 0;
    int   mf_sub      = 0;
    int   mf_carry    = 0;
    int   mf_idx      = 0;

    // m_ready policy: 0 = always ready, 1 = random, 2 = stalled.
    int   rdy_mode = 0;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0)      m_ready = 1'b1;
        else if (rdy_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
        else                    m_ready = 1'b0;
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Arithmetic reference: multi-precision add/sub with signed overflow on the top word.
    function automatic exp_t model(input int a, input int b, input int first, input int last, input int sub);
        exp_t e;
        int   start, cin, t, sa, sb, sr;
        start = (mf_in_frame == 0) || (first != 0);
        e.err = (mf_in_frame == 0) ? (first == 0) : (first != 0);
        if (start) begin
            mf_sub = sub;
            mf_idx = 0;
            cin    = sub;
        end else begin
            mf_idx = (mf_idx + 1) % 256;
            cin    = mf_carry;
        end
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        if (mf_sub != 0) begin
            t  = 256 + a - b - (1 - cin);
            sr = sa - sb - (1 - cin);
        end else begin
            t  = a + b + cin;
            sr = sa + sb + cin;
        end
        mf_carry    = (t >= 256) ? 1 : 0;
        mf_in_frame = (last != 0) ? 0 : 1;
        e.sum  = N'(t % 256);
        e.co   = (t >= 256);
        e.idx  = IDXW'(mf_idx);
        e.last = (last != 0);
        e.ovf  = (last != 0) && (sr > 127 || sr < -128);
        return e;
    endfunction

    task automatic send(input int a, input int b, input int first, input int last, input int sub);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_a     = N'(a);
        s_b     = N'(b);
        s_first = first[0];
        s_last  = last[0];
        s_sub   = sub[0];
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (s_ready) begin
                sb_q.push_back(model(a, b, first, last, sub));
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got s_ready 0 want 1 at %0t", $time);
        end
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_outs"}, int'({m_sum, m_idx, m_last, m_co, m_ovf, m_err}), 0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        mf_in_frame = 0;
        mf_sub      = 0;
        mf_carry    = 0;
        mf_idx      = 0;
    endtask

    // Monitor: pops the scoreboard on each transfer and checks that stalled outputs hold.
    exp_t snap;
    bit   held = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_cmp++;
                if (!m_valid || {m_sum, m_idx, m_last, m_co, m_ovf, m_err} != snap) begin
                    n_err++;
                    $display("FAIL hold: got %0h valid %0b want %0h at %0t",
                             {m_sum, m_idx, m_last, m_co, m_ovf, m_err}, m_valid, snap, $time);
                end
            end
            if (m_valid && !m_ready) begin
                n_cmp++;
                if (s_ready) begin
                    n_err++;
                    $display("FAIL s_ready_stall: got 1 want 0 at %0t", $time);
                end
                held = 1'b1;
                snap = {m_sum, m_idx, m_last, m_co, m_ovf, m_err};
            end else begin
                held = 1'b0;
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got sum %0h want none at %0t", m_sum, $time);
                end else begin
                    e = sb_q.pop_front();
                    if ({m_sum, m_idx, m_last, m_co, m_ovf, m_err} != e) begin
                        n_err++;
                        $display("FAIL result: got sum %0h idx %0d last %0b co %0b ovf %0b err %0b want sum %0h idx %0d last %0b co %0b ovf %0b err %0b at %0t",
                                 m_sum, m_idx, m_last, m_co, m_ovf, m_err,
                                 e.sum, e.idx, e.last, e.co, e.ovf, e.err, $time);
                    end
                end
            end
        end
    end

    initial begin
        int first, last;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("reset_s_ready", int'(s_ready), 1);

        // Add 0x00FF + 0x0001
        send(8'hFF, 8'h01, 1, 0, 0);
        send(8'h00, 8'h00, 0, 1, 0);
        // Subtract 0x0100 - 0x0001
        send(8'h00, 8'h01, 1, 0, 1);
        send(8'h01, 8'h00, 0, 1, 1);
        // Single-word frames with signed overflow
        send(8'h7F, 8'h01, 1, 1, 0);
        send(8'h80, 8'h01, 1, 1, 1);

        // Backpressure on a three-word frame
        rdy_mode = 2;
        fork
            begin
                send(8'hFF, 8'hFF, 1, 0, 0);
                send(8'hFF, 8'h00, 0, 0, 0);
                send(8'h12, 8'h34, 0, 1, 0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_s_ready", int'(s_ready), 0);
                check("bp_m_valid", int'(m_valid), 1);
                rdy_mode = 0;
            end
        join

        // Framing: restart inside a frame, then a headless word in IDLE
        send(8'hFF, 8'h01, 1, 0, 0);
        send(8'h05, 8'h03, 1, 1, 1);
        send(8'h10, 8'h20, 0, 1, 0);

        // Reset mid-frame drops the carry and the pending result
        send(8'hFF, 8'h01, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_reset_outputs("midreset");
        rst = 1'b0;
        #1;
        check("midreset_s_ready", int'(s_ready), 1);
        send(8'h00, 8'h00, 0, 1, 0);

        // Randomized frames under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if (mf_in_frame != 0) first = ($urandom_range(0, 15) == 0);
            else                  first = ($urandom_range(0, 15) != 0);
            last = ($urandom_range(0, 3) == 0);
            send($urandom_range(0, 255), $urandom_range(0, 255), first, last, $urandom_range(0, 1));
        end

        // Drain
        rdy_mode = 0;
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        check("drain_queue_empty", sb_q.size(), 0);
        #1;
        check("drain_m_valid", int'(m_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
